// File: rtl/mem_arbiter.sv
// Two-port (I/D cache) arbiter onto one slow memory: latches the winning command, one transfer at a time.
// Strobe 1 cycle after request; ready passes straight from memory; one IDLE bubble between transfers. Build option: MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t            state;
    logic              last_grant_d;
    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    // On a tie, hand the grant to whoever did not win last time.
    assign grant_d = d_req && (!i_req || !last_grant_d);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state        <= grant_d ? SERVE_D : SERVE_I;
                        last_grant_d <= grant_d;
                        addr_q       <= grant_d ? d_addr  : i_addr;
                        wdata_q      <= grant_d ? d_wdata : i_wdata;
                        // A write takes precedence when both strobes are up.
                        write_q      <= grant_d ? d_write : i_write;
                        read_q       <= grant_d ? (d_read && !d_write) : (i_read && !i_write);
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read  = read_q;
    assign mem_write = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // last_grant always names the requester currently being served.
    assign i_ready = (state != IDLE) && !last_grant_d && mem_ready;
    assign d_ready = (state != IDLE) &&  last_grant_d && mem_ready;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning line-address width (address bits [31:4]).
REQ-002 SHALL have parameter DATA_W, default 128, meaning cache-line width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports i_read, i_write  input  1 each  I-cache request strobes, held until i_ready.
REQ-006 SHALL have ports i_addr  input  ADDR_W, i_wdata  input  DATA_W  I-cache command.
REQ-007 SHALL have ports i_rdata  output  DATA_W, i_ready  output  1  I-cache response.
REQ-008 SHALL have ports d_read, d_write, d_addr, d_wdata, d_rdata, d_ready, with the same widths and directions as the i_* set, for the D-cache.
REQ-009 SHALL have ports mem_read, mem_write  output  1, mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  toward the shared slow memory.
REQ-010 SHALL have ports mem_rdata  input  DATA_W, mem_ready  input  1  from the slow memory.

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-012 In IDLE with any request pending at a clock edge, SHALL move to SERVE_x and latch the winner's addr, wdata and command into registers on that edge.
REQ-013 A requester with read and write both high SHALL be treated as a write.
REQ-014 mem_read/mem_write/mem_addr/mem_wdata SHALL be driven only from the latched registers; requester inputs are ignored while in SERVE_x.
REQ-015 mem_read and mem_write SHALL be 0 in IDLE and at most one SHALL be 1 in SERVE_x.
REQ-016 Latency: request first high in cycle t (FSM in IDLE) -> memory strobe high in cycle t+1.
REQ-017 In SERVE_x, x_ready SHALL equal mem_ready, combinationally, in the same cycle; the other requester's ready SHALL be 0.
REQ-018 i_rdata and d_rdata SHALL both equal mem_rdata; they are valid only while the matching ready is 1.
REQ-019 At the edge where mem_ready=1 in SERVE_x, the FSM SHALL return to IDLE, giving one idle bubble cycle before the next memory strobe.
REQ-020 A granted requester dropping its request before mem_ready SHALL NOT abort the transaction; the FSM waits for mem_ready.
REQ-021 mem_ready asserted while in IDLE SHALL be ignored: no ready output and no state change.
REQ-022 The FSM SHALL keep a last_grant register, updated to the winner on every grant.

Reset
REQ-023 With rst=1 at an edge, the FSM SHALL go to IDLE, latched command registers to 0, and last_grant to I.
REQ-024 During and after reset, mem_read, mem_write, i_ready and d_ready SHALL all be 0.
REQ-025 Reset mid-transaction SHALL abandon the transfer; a later mem_ready SHALL be ignored per REQ-021.

Configuration
REQ-026 With macro MEM_ARB_RR_EN defined, simultaneous I and D requests in IDLE SHALL be granted to the requester that is not last_grant (round-robin).
REQ-027 Without MEM_ARB_RR_EN, simultaneous requests SHALL always grant D (fixed priority); last_grant SHALL still be maintained.

Verification
REQ-028 Single I read, addr 0x0000010, memory ready 4 cycles after strobe -> mem_read=1 with mem_addr=0x0000010, i_ready pulses 1 cycle with i_rdata=mem_rdata, d_ready stays 0.
REQ-029 D write, addr 0x0000020, wdata all-0xA5; d_addr changed to 0x0000030 mid-transfer -> mem_write=1 and mem_addr stays 0x0000020 until mem_ready.
REQ-030 I read and D read raised in the same cycle and held, without the macro -> D served first, then I; gap of one cycle with mem_read=0 between the two.
REQ-031 Same stimulus, with MEM_ARB_RR_EN, four back-to-back request pairs -> grant order D,I,D,I,D,I,D,I.
REQ-032 rst pulsed for 1 cycle while in SERVE_D, then mem_ready pulsed -> mem_read/mem_write low the cycle after reset, no d_ready, FSM in IDLE.
REQ-033 Both read and write high on I -> mem_write=1 and mem_read=0 for the whole transfer.
